// File: rtl/lrwait_queue_node_pkg.sv
// ---------------------------------------------------------------------------
// lrwait_queue_node_pkg
// Shared types and constants for the LRWait/SCWait queue node.
//   - AMO_LR / AMO_SC : amo encodings of LRWait and SCWait
//   - meta_id_t       : request/response ID at the default width
//   - lrwait_req_t    : sideband on a request  {succ_id, wakeup}
//   - lrwait_rsp_t    : sideband on a response {succ_id, succ_update}
//   - node_state_e    : queue node FSM states
// ---------------------------------------------------------------------------
package lrwait_queue_node_pkg;

  localparam int unsigned MetaIdWidthDef = 5;
  localparam int unsigned CoreIdWidthDef = 8;

  localparam logic [3:0] AMO_LR = 4'hA;
  localparam logic [3:0] AMO_SC = 4'hB;

  typedef logic [MetaIdWidthDef-1:0] meta_id_t;

  // Bit 0 is the flag, the successor core ID sits above it.
  typedef struct packed {
    logic [CoreIdWidthDef-1:0] succ_id;
    logic                      wakeup;
  } lrwait_req_t;

  typedef struct packed {
    logic [CoreIdWidthDef-1:0] succ_id;
    logic                      succ_update;
  } lrwait_rsp_t;

  typedef enum logic {
    PASS   = 1'b0,
    WAKEUP = 1'b1
  } node_state_e;

endpackage

// File: rtl/lrwait_queue_node.sv
// ---------------------------------------------------------------------------
// lrwait_queue_node
// Core-side half of the LRWait/SCWait queue reservation protocol. Sits
// between the Snitch TCDM data port and the tile interconnect.
//   - snitch_q* / tile_q* : request path, combinational pass-through in PASS;
//                           in WAKEUP the node owns the tile request port and
//                           issues a wake-up to the queued successor.
//   - tile_p* / snitch_p* : response path, combinational pass-through, except
//                           successor updates (tile_plrwait_i[0]) which are
//                           absorbed locally and never reach the core.
//   - clk_i, rst_i        : clock, asynchronous active-high reset.
// ---------------------------------------------------------------------------
module lrwait_queue_node
  import lrwait_queue_node_pkg::*;
#(
  parameter int unsigned MetaIdWidth = 5,
  parameter int unsigned CoreIdWidth = 8,
  parameter logic [3:0]  AmoLr       = AMO_LR,
  parameter logic [3:0]  AmoSc       = AMO_SC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            snitch_qaddr_i,
  input  logic                   snitch_qwrite_i,
  input  logic [3:0]             snitch_qamo_i,
  input  logic [31:0]            snitch_qdata_i,
  input  logic [3:0]             snitch_qstrb_i,
  input  logic [MetaIdWidth-1:0] snitch_qid_i,
  input  logic                   snitch_qvalid_i,
  output logic                   snitch_qready_o,
  output logic [31:0]            snitch_pdata_o,
  output logic                   snitch_perror_o,
  output logic [MetaIdWidth-1:0] snitch_pid_o,
  output logic                   snitch_pvalid_o,
  input  logic                   snitch_pready_i,
  output logic [31:0]            tile_qaddr_o,
  output logic                   tile_qwrite_o,
  output logic [3:0]             tile_qamo_o,
  output logic [31:0]            tile_qdata_o,
  output logic [3:0]             tile_qstrb_o,
  output logic [MetaIdWidth-1:0] tile_qid_o,
  output logic [CoreIdWidth:0]   tile_qlrwait_o,
  output logic                   tile_qvalid_o,
  input  logic                   tile_qready_i,
  input  logic [31:0]            tile_pdata_i,
  input  logic                   tile_perror_i,
  input  logic [MetaIdWidth-1:0] tile_pid_i,
  input  logic [CoreIdWidth:0]   tile_plrwait_i,
  input  logic                   tile_pvalid_i,
  output logic                   tile_pready_o
);

  node_state_e             state_q;
  logic                    succ_valid_q;
  logic [CoreIdWidth-1:0]  succ_id_q;
  logic                    sc_pending_q;
  logic [MetaIdWidth-1:0]  sc_id_q;
  logic [31:0]             sc_addr_q;
  logic                    lr_outstanding_q;

  logic upd_s;
  logic upd_acc_s;
  logic req_acc_s;
  logic wake_acc_s;
  logic fwd_hs_s;
  logic sc_done_s;
  logic go_wakeup_s;

  assign upd_s      = tile_plrwait_i[0];
  assign upd_acc_s  = tile_pvalid_i & upd_s;   // updates are always accepted
  assign req_acc_s  = snitch_qvalid_i & snitch_qready_o;
  assign wake_acc_s = (state_q == WAKEUP) & tile_qready_i;
  assign fwd_hs_s   = tile_pvalid_i & ~upd_s & snitch_pready_i;
  assign sc_done_s  = fwd_hs_s & sc_pending_q & (tile_pid_i == sc_id_q);

  // Wake-up is due when our SC finishes with a successor known (or arriving
  // now), or when a successor registers after our reservation is already over.
  assign go_wakeup_s = (sc_done_s & (succ_valid_q | upd_acc_s))
                     | (upd_acc_s & ~sc_pending_q & ~lr_outstanding_q);

  // Request path: pass-through in PASS, node-generated wake-up in WAKEUP.
  always_comb begin
    tile_qaddr_o    = snitch_qaddr_i;
    tile_qwrite_o   = snitch_qwrite_i;
    tile_qamo_o     = snitch_qamo_i;
    tile_qdata_o    = snitch_qdata_i;
    tile_qstrb_o    = snitch_qstrb_i;
    tile_qid_o      = snitch_qid_i;
    tile_qlrwait_o  = {(CoreIdWidth+1){1'b0}};
    tile_qvalid_o   = snitch_qvalid_i;
    snitch_qready_o = tile_qready_i;
    case (state_q)
      WAKEUP: begin
        tile_qaddr_o    = sc_addr_q;
        tile_qwrite_o   = 1'b0;
        tile_qamo_o     = 4'h0;
        tile_qdata_o    = 32'h0;
        tile_qstrb_o    = 4'h0;
        tile_qid_o      = sc_id_q;
        tile_qlrwait_o  = {succ_id_q, 1'b1};
        tile_qvalid_o   = 1'b1;
        snitch_qready_o = 1'b0;
      end
      PASS: begin
        tile_qvalid_o   = snitch_qvalid_i;
        snitch_qready_o = tile_qready_i;
      end
      default: begin
        tile_qvalid_o   = snitch_qvalid_i;
        snitch_qready_o = tile_qready_i;
      end
    endcase
  end

  // Response path: forward ordinary responses, swallow successor updates.
  always_comb begin
    snitch_pdata_o  = tile_pdata_i;
    snitch_perror_o = tile_perror_i;
    snitch_pid_o    = tile_pid_i;
    if (upd_s) begin
      snitch_pvalid_o = 1'b0;
      tile_pready_o   = 1'b1;
    end else begin
      snitch_pvalid_o = tile_pvalid_i;
      tile_pready_o   = snitch_pready_i;
    end
  end

  // Successor register: a fresh update wins over clearing by the wake-up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      succ_valid_q <= 1'b0;
      succ_id_q    <= {CoreIdWidth{1'b0}};
    end else if (upd_acc_s) begin
      succ_valid_q <= 1'b1;
      succ_id_q    <= tile_plrwait_i[CoreIdWidth:1];
    end else if (wake_acc_s) begin
      succ_valid_q <= 1'b0;
    end
  end

  // SC / LR reservation tracking; a new request takes priority over clearing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sc_pending_q     <= 1'b0;
      sc_id_q          <= {MetaIdWidth{1'b0}};
      sc_addr_q        <= 32'h0;
      lr_outstanding_q <= 1'b0;
    end else begin
      if (req_acc_s && (snitch_qamo_i == AmoSc)) begin
        sc_pending_q <= 1'b1;
        sc_id_q      <= snitch_qid_i;
        sc_addr_q    <= snitch_qaddr_i;
      end else if (sc_done_s) begin
        sc_pending_q <= 1'b0;
      end
      if (req_acc_s && (snitch_qamo_i == AmoLr)) begin
        lr_outstanding_q <= 1'b1;
      end else if (sc_done_s) begin
        lr_outstanding_q <= 1'b0;
      end
    end
  end

  // Node FSM: enter WAKEUP after reservation hand-off is due, leave on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PASS;
    end else begin
      case (state_q)
        PASS:    if (go_wakeup_s)   state_q <= WAKEUP;
        WAKEUP:  if (tile_qready_i) state_q <= PASS;
        default: state_q <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_lrwait_queue_node.sv
module tb_lrwait_queue_node;

  localparam logic [3:0] LR = 4'hA;
  localparam logic [3:0] SC = 4'hB;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] snitch_qaddr_i, snitch_qdata_i, snitch_pdata_o;
  logic        snitch_qwrite_i, snitch_qvalid_i, snitch_qready_o;
  logic [3:0]  snitch_qamo_i, snitch_qstrb_i;
  logic [4:0]  snitch_qid_i, snitch_pid_o;
  logic        snitch_perror_o, snitch_pvalid_o, snitch_pready_i;
  logic [31:0] tile_qaddr_o, tile_qdata_o, tile_pdata_i;
  logic        tile_qwrite_o, tile_qvalid_o, tile_qready_i;
  logic [3:0]  tile_qamo_o, tile_qstrb_o;
  logic [4:0]  tile_qid_o, tile_pid_i;
  logic [8:0]  tile_qlrwait_o, tile_plrwait_i;
  logic        tile_perror_i, tile_pvalid_i, tile_pready_o;

  always #5 clk = ~clk;

  lrwait_queue_node dut (
    .clk_i(clk), .rst_i(rst_i),
    .snitch_qaddr_i(snitch_qaddr_i), .snitch_qwrite_i(snitch_qwrite_i),
    .snitch_qamo_i(snitch_qamo_i), .snitch_qdata_i(snitch_qdata_i),
    .snitch_qstrb_i(snitch_qstrb_i), .snitch_qid_i(snitch_qid_i),
    .snitch_qvalid_i(snitch_qvalid_i), .snitch_qready_o(snitch_qready_o),
    .snitch_pdata_o(snitch_pdata_o), .snitch_perror_o(snitch_perror_o),
    .snitch_pid_o(snitch_pid_o), .snitch_pvalid_o(snitch_pvalid_o),
    .snitch_pready_i(snitch_pready_i),
    .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o),
    .tile_qamo_o(tile_qamo_o), .tile_qdata_o(tile_qdata_o),
    .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
    .tile_qlrwait_o(tile_qlrwait_o), .tile_qvalid_o(tile_qvalid_o),
    .tile_qready_i(tile_qready_i),
    .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i),
    .tile_pid_i(tile_pid_i), .tile_plrwait_i(tile_plrwait_i),
    .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o)
  );

  typedef struct packed {
    logic [31:0] addr; logic write; logic [3:0] amo; logic [31:0] data;
    logic [3:0] strb; logic [4:0] id; logic [8:0] lrw;
  } treq_t;

  typedef struct packed {
    logic [31:0] data; logic err; logic [4:0] id;
  } trsp_t;

  typedef struct packed {
    logic qv; logic [31:0] qaddr; logic qwrite; logic [3:0] qamo;
    logic [31:0] qdata; logic [3:0] qstrb; logic [4:0] qid; logic qr;
    logic pv; logic [31:0] pdata; logic perr; logic [4:0] pid;
    logic [8:0] plr; logic pr;
  } stim_t;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  treq_t req_q[$];
  trsp_t rsp_q[$];

  // Reference model: the reservation as the core sees it.
  bit         m_wake, m_succ_known, m_sc_open, m_lr_open;
  logic [7:0] m_succ;
  logic [4:0] m_sc_id;
  logic [31:0] m_sc_addr;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic treq_t wake_req();
    treq_t t;
    t.addr = m_sc_addr; t.write = 1'b0; t.amo = 4'h0; t.data = 32'h0;
    t.strb = 4'h0; t.id = m_sc_id; t.lrw = {m_succ, 1'b1};
    return t;
  endfunction

  task automatic model_reset();
    m_wake = 1'b0; m_succ_known = 1'b0; m_sc_open = 1'b0; m_lr_open = 1'b0;
    m_succ = 8'h0; m_sc_id = 5'h0; m_sc_addr = 32'h0;
    req_q.delete(); rsp_q.delete();
  endtask

  function automatic stim_t idle(input logic qr);
    stim_t s = '0;
    s.qr = qr; s.pr = 1'b1;
    return s;
  endfunction

  // Drive one cycle, predict its effect, advance to the next edge.
  task automatic step(input stim_t s);
    bit req_taken, wake_taken, upd, rsp_taken, sc_fin;
    bit n_wake, n_known, n_sc_open, n_lr;
    logic [7:0] n_succ; logic [4:0] n_sc_id; logic [31:0] n_sc_addr;
    treq_t t; trsp_t r;
    snitch_qvalid_i = s.qv; snitch_qaddr_i = s.qaddr; snitch_qwrite_i = s.qwrite;
    snitch_qamo_i = s.qamo; snitch_qdata_i = s.qdata; snitch_qstrb_i = s.qstrb;
    snitch_qid_i = s.qid; tile_qready_i = s.qr; tile_pvalid_i = s.pv;
    tile_pdata_i = s.pdata; tile_perror_i = s.perr; tile_pid_i = s.pid;
    tile_plrwait_i = s.plr; snitch_pready_i = s.pr;

    req_taken  = !m_wake && s.qv && s.qr;
    wake_taken = m_wake && s.qr;
    upd        = s.pv && s.plr[0];
    rsp_taken  = s.pv && !s.plr[0] && s.pr;
    sc_fin     = rsp_taken && m_sc_open && (s.pid == m_sc_id);

    if (req_taken) begin
      t.addr = s.qaddr; t.write = s.qwrite; t.amo = s.qamo; t.data = s.qdata;
      t.strb = s.qstrb; t.id = s.qid; t.lrw = 9'h0;
      req_q.push_back(t);
    end
    if (wake_taken) req_q.push_back(wake_req());
    if (rsp_taken) begin
      r.data = s.pdata; r.err = s.perr; r.id = s.pid;
      rsp_q.push_back(r);
    end

    n_known = upd ? 1'b1 : (wake_taken ? 1'b0 : m_succ_known);
    n_succ  = upd ? s.plr[8:1] : m_succ;
    n_sc_open = m_sc_open; n_sc_id = m_sc_id; n_sc_addr = m_sc_addr;
    if (req_taken && s.qamo == SC) begin
      n_sc_open = 1'b1; n_sc_id = s.qid; n_sc_addr = s.qaddr;
    end else if (sc_fin) n_sc_open = 1'b0;
    n_lr = (req_taken && s.qamo == LR) ? 1'b1 : (sc_fin ? 1'b0 : m_lr_open);
    if (m_wake) n_wake = !wake_taken;
    else n_wake = (sc_fin && (m_succ_known || upd)) || (upd && !m_sc_open && !m_lr_open);

    @(posedge clk);
    m_wake = n_wake; m_succ_known = n_known; m_succ = n_succ;
    m_sc_open = n_sc_open; m_sc_id = n_sc_id; m_sc_addr = n_sc_addr; m_lr_open = n_lr;
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] amo, input logic [4:0] id);
    stim_t s = idle(1'b1);
    s.qv = 1'b1; s.qaddr = a; s.qamo = amo; s.qid = id; s.qstrb = 4'hF;
    step(s);
  endtask

  task automatic rsp(input logic [31:0] d, input logic [4:0] id, input logic [8:0] plr,
                     input logic pr, input logic qr);
    stim_t s = idle(qr);
    s.pv = 1'b1; s.pdata = d; s.pid = id; s.plr = plr; s.pr = pr;
    step(s);
  endtask

  // Monitor: per-cycle handshake signals and scoreboard pops.
  always @(negedge clk) begin
    if (mon_en) begin
      treq_t got, e;
      trsp_t pg, pe;
      check("tile_qvalid", tile_qvalid_o, m_wake ? 1'b1 : snitch_qvalid_i);
      check("snitch_qready", snitch_qready_o, m_wake ? 1'b0 : tile_qready_i);
      check("tile_pready", tile_pready_o, tile_plrwait_i[0] ? 1'b1 : snitch_pready_i);
      check("snitch_pvalid", snitch_pvalid_o, tile_pvalid_i & ~tile_plrwait_i[0]);
      got = {tile_qaddr_o, tile_qwrite_o, tile_qamo_o, tile_qdata_o,
             tile_qstrb_o, tile_qid_o, tile_qlrwait_o};
      if (m_wake) check("wake_hold", got, wake_req());
      if (tile_qvalid_o && tile_qready_i) begin
        if (req_q.size() == 0) check("tile_req_unexpected", 1'b1, 1'b0);
        else begin
          e = req_q.pop_front();
          check("tile_req", got, e);
        end
      end
      if (snitch_pvalid_o && snitch_pready_i) begin
        pg = {snitch_pdata_o, snitch_perror_o, snitch_pid_o};
        if (rsp_q.size() == 0) check("snitch_rsp_unexpected", 1'b1, 1'b0);
        else begin
          pe = rsp_q.pop_front();
          check("snitch_rsp", pg, pe);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int r;
    model_reset();
    rst_i = 1'b1;
    snitch_qvalid_i = 1'b0; snitch_qaddr_i = 32'h0; snitch_qwrite_i = 1'b0;
    snitch_qamo_i = 4'h0; snitch_qdata_i = 32'h0; snitch_qstrb_i = 4'h0;
    snitch_qid_i = 5'h0; tile_qready_i = 1'b1; tile_pvalid_i = 1'b0;
    tile_pdata_i = 32'h0; tile_perror_i = 1'b0; tile_pid_i = 5'h0;
    tile_plrwait_i = 9'h0; snitch_pready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_qvalid", tile_qvalid_o, 1'b0);
    check("reset_qready", snitch_qready_o, 1'b1);
    check("reset_qlrwait", tile_qlrwait_o, 9'h0);
    rst_i = 1'b0;
    mon_en = 1'b1;

    // Plain load and its response.
    req(32'h100, 4'h0, 5'd3);
    rsp(32'hDEAD, 5'd3, 9'h0, 1'b1, 1'b1);

    // LR, SC, successor 7 registers before the SC response; wake-up stalls 3 cycles
    // while an ordinary response is forwarded and the core is held off.
    req(32'h200, LR, 5'd1);
    req(32'h200, SC, 5'd5);
    rsp(32'h0, 5'd0, {8'd7, 1'b1}, 1'b0, 1'b1);
    rsp(32'h1, 5'd5, 9'h0, 1'b1, 1'b1);
    check("wake_entered", m_wake, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s = idle(1'b0);
      s.qv = 1'b1; s.qaddr = 32'h444; s.qid = 5'd9;
      s.pv = 1'b1; s.pdata = 32'hBEEF0 + i; s.pid = 5'd1; s.pr = 1'b1;
      step(s);
    end
    step(idle(1'b1));

    // Successor 2 registers only after the SC completed.
    req(32'h300, LR, 5'd2);
    req(32'h300, SC, 5'd6);
    rsp(32'h0, 5'd6, 9'h0, 1'b1, 1'b1);
    rsp(32'h0, 5'd0, {8'd2, 1'b1}, 1'b0, 1'b1);
    step(idle(1'b1));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.qv = 1'($urandom_range(0, 1));
      s.qaddr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      s.qwrite = 1'($urandom_range(0, 1));
      s.qdata = $urandom; s.qstrb = 4'($urandom_range(0, 15));
      s.qid = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 5);
      case (r)
        3: s.qamo = LR;
        4: s.qamo = m_sc_open ? 4'h0 : SC;
        5: s.qamo = 4'h2;
        default: s.qamo = 4'h0;
      endcase
      s.qr = ($urandom_range(0, 3) != 0);
      s.pv = 1'($urandom_range(0, 1));
      s.pdata = $urandom; s.perr = 1'($urandom_range(0, 1));
      s.pid = (m_sc_open && $urandom_range(0, 1)) ? m_sc_id : 5'($urandom_range(0, 31));
      s.plr = {8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0)};
      s.pr = ($urandom_range(0, 3) != 0);
      step(s);
    end
    repeat (6) step(idle(1'b1));
    check("req_queue_drained", req_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);

    // Reset while a wake-up is stalled.
    req(32'h500, LR, 5'd4);
    req(32'h500, SC, 5'd8);
    rsp(32'h0, 5'd0, {8'd3, 1'b1}, 1'b0, 1'b1);
    rsp(32'h0, 5'd8, 9'h0, 1'b1, 1'b1);
    step(idle(1'b0));
    check("pre_reset_wake", m_wake, 1'b1);
    mon_en = 1'b0;
    snitch_qvalid_i = 1'b1;
    rst_i = 1'b1;
    #1;
    check("rst_qvalid_follow_1", tile_qvalid_o, 1'b1);
    check("rst_qlrwait", tile_qlrwait_o, 9'h0);
    snitch_qvalid_i = 1'b0;
    #1;
    check("rst_qvalid_follow_0", tile_qvalid_o, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    mon_en = 1'b1;
    repeat (5) step(idle(1'b1));
    check("post_reset_queue", req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lrwait_queue_node.md
Name: lrwait_queue_node

Overview:
- Per-core queue node between the Snitch TCDM data port and the tile interconnect. It implements the core-side half of the LRWait/SCWait queue-based reservation protocol.
- Ordinary requests and responses pass through combinationally.
- The node captures successor notifications from memory and holds them locally; they are never forwarded to the core.
- After its own SCWait completes, the node issues a wake-up request that hands the reservation to the successor core.

Parameters:
- MetaIdWidth, default 5: width of request/response ID.
- CoreIdWidth, default 8: width of successor core ID.
- AmoLr, default 4'hA: amo encoding of LRWait.
- AmoSc, default 4'hB: amo encoding of SCWait.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- snitch_qaddr_i  in  32  core request address.
- snitch_qwrite_i  in  1  core request write.
- snitch_qamo_i  in  4  core request amo.
- snitch_qdata_i  in  32  core request data.
- snitch_qstrb_i  in  4  core request byte strobe.
- snitch_qid_i  in  MetaIdWidth  core request ID.
- snitch_qvalid_i  in  1  core request valid.
- snitch_qready_o  out  1  core request ready.
- snitch_pdata_o  out  32  response data to core.
- snitch_perror_o  out  1  response error to core.
- snitch_pid_o  out  MetaIdWidth  response ID to core.
- snitch_pvalid_o  out  1  response valid to core.
- snitch_pready_i  in  1  response ready from core.
- tile_qaddr_o, tile_qwrite_o, tile_qamo_o, tile_qdata_o, tile_qstrb_o, tile_qid_o  out  32/1/4/32/4/MetaIdWidth  request to interconnect.
- tile_qlrwait_o  out  1+CoreIdWidth  bit0 = wake-up flag, [CoreIdWidth:1] = successor ID.
- tile_qvalid_o  out  1  request valid to interconnect.
- tile_qready_i  in  1  request ready from interconnect.
- tile_pdata_i, tile_perror_i, tile_pid_i  in  32/1/MetaIdWidth  response from interconnect.
- tile_plrwait_i  in  1+CoreIdWidth  bit0 = successor-update flag, upper bits = successor ID.
- tile_pvalid_i  in  1  response valid from interconnect.
- tile_pready_o  out  1  response ready to interconnect.

Behaviour:
- Registered state:
  - succ_valid_q (reset 0), succ_id_q (reset 0).
  - sc_pending_q (reset 0), with sc_id_q capturing the SC request ID.
  - state in {PASS, WAKEUP}, reset PASS.
- Request path in PASS:
  - All tile_q* fields equal the snitch_q* fields.
  - tile_qlrwait_o = 0.
  - tile_qvalid_o = snitch_qvalid_i; snitch_qready_o = tile_qready_i.
- SC tracking:
  - Fires on an accepted request (snitch_qvalid_i & snitch_qready_o) with snitch_qamo_i == AmoSc.
  - Sets sc_pending_q and captures sc_id_q.
- Response path, tile_plrwait_i[0] == 0:
  - Forwarded combinationally: snitch_p* = tile_p*; tile_pready_o = snitch_pready_i.
- Response path, tile_plrwait_i[0] == 1 (successor update):
  - tile_pready_o = 1 and snitch_pvalid_o = 0.
  - On tile_pvalid_i: succ_valid_q <= 1; succ_id_q <= tile_plrwait_i[CoreIdWidth:1].
  - A later update overwrites an earlier one.
- SC completion:
  - Defined as a forwarded response handshake whose tile_pid_i == sc_id_q while sc_pending_q is set.
  - Clears sc_pending_q.
  - If succ_valid_q, or a successor update is accepted in the same cycle, next state is WAKEUP.
- Successor update while idle:
  - If an update is accepted while sc_pending_q == 0 and no LR is outstanding, next state is WAKEUP.
  - This resolves the case where the successor registered after the SC completed.
- LR tracking:
  - An accepted request with amo == AmoLr sets lr_outstanding_q.
  - The matching response does not clear it; the next SC completion clears it.
- WAKEUP state:
  - snitch_qready_o = 0.
  - tile_qvalid_o = 1, tile_qwrite_o = 0, tile_qamo_o = 0, tile_qstrb_o = 0, tile_qdata_o = 0.
  - tile_qaddr_o = address of the last SCWait, held in a register captured with the SC.
  - tile_qid_o = sc_id_q.
  - tile_qlrwait_o = {succ_id_q, 1'b1}.
  - On tile_qready_i: succ_valid_q <= 0, state <= PASS.
  - The response path stays live in WAKEUP.
- Latency:
  - Pass-through: 0 cycles.
  - Wake-up: issued the cycle after SC completion, and held until accepted.
- Reset:
  - Asserting reset mid-operation clears all state and returns to PASS.
  - Any queued successor is dropped.

Decomposition:
- Shared package: lrwait request struct {wakeup, succ_id}, lrwait response struct {succ_update, succ_id}, AmoLr/AmoSc constants, meta_id_t.
- Single module; no sub-module needed.

Test Plan:
- Plain load: snitch load addr 0x100, id 3 → identical tile request same cycle; tile response data 0xDEAD, id 3 → snitch receives 0xDEAD.
- LR, successor update, SC: LR(0x200), SC(0x200, id 5), update with succ 7 before the SC response, SC response id 5 → next cycle tile request addr 0x200, lrwait = {7,1}; snitch_qready_o = 0 until accepted.
- Successor update after SC completion: LR, SC completes, then update succ 2 → wake-up {2,1} issued the following cycle.
- Wake-up stall: WAKEUP with tile_qready_i = 0 for 3 cycles → request held stable and snitch blocked; core response forwarded meanwhile.
- Update never forwarded: tile response with plrwait[0] = 1 → snitch_pvalid_o stays 0 and tile_pready_o = 1 even with snitch_pready_i = 0.
- Reset mid-WAKEUP: assert rst_i → tile_qvalid_o follows snitch_qvalid_i immediately and no wake-up is issued after reset.
